dcpu_ram_responder: RTL
=======================

// Module: dcpu_ram_responder
// PURPOSE
//  Memory responder for the DCPU core's RAM bus: serves CPU reads/writes on RAM_addr/RAM_out/RAM_wr/RAM_data.
//  Provides a second device port (display fetch, loader DMA) onto the same word store.
//  Clocked on posedge CORE_CLK, opposite the CPU's negedge, so read data is stable when the CPU samples.
//  Optional post-reset clear sweep zeroes the memory before the CPU is released.
// PARAMETERS
//  ADDR_W          16  word address width; depth = 2**ADDR_W words
//  DATA_W          16  word width
//  CLEAR_ON_RESET  1   1: zero all words after reset (CLEAR state); 0: go straight to RUN
// PORTS
//  CORE_CLK     in   1       core clock; all state updates on posedge
//  RESET        in   1       reset, asynchronous, active-high
//  RAM_addr     in   ADDR_W  CPU word address
//  RAM_out      in   DATA_W  CPU write data
//  RAM_wr       in   1       CPU write strobe
//  RAM_data     out  DATA_W  CPU read data (registered)
//  ready        out  1       1 = clear sweep done, memory serving requests
//  dev_req      in   1       device access request
//  dev_addr     in   ADDR_W  device word address
//  dev_wdata    in   DATA_W  device write data
//  dev_we       in   1       device write enable (valid with dev_req)
//  dev_gnt      out  1       combinational: dev_req & ready; access is taken at this posedge
//  dev_rdata    out  DATA_W  device read data (registered)
//  dev_valid    out  1       1-cycle pulse: dev_rdata holds data for the granted read of the previous cycle
//  dev_collide  out  1       1-cycle pulse: device write dropped because of a same-address CPU write
//  parity_err   out  1       sticky parity error flag (see CONFIGURATION)
// BEHAVIOUR
//  Reset values: RAM_data=0, dev_rdata=0, ready=0, dev_valid=0, dev_collide=0, parity_err=0, clear counter=0.
//  State machine: CLEAR -> RUN.
//   On RESET the state becomes CLEAR if CLEAR_ON_RESET=1, else RUN with ready=1.
//  CLEAR: each posedge writes 0 to mem[cnt] and increments cnt.
//   - After writing word 2**ADDR_W-1: state -> RUN; ready=1 from that edge on.
//   - Total is exactly 2**ADDR_W posedges after reset release.
//   - CPU writes are ignored, RAM_data is held at 0, dev_gnt=0.
//  RUN, CPU port:
//   - Each posedge: if RAM_wr, mem[RAM_addr] <= RAM_out.
//   - RAM_data <= mem[RAM_addr], write-first: a write and a read of the same address on one edge returns RAM_out.
//   - Latency is one posedge; the CPU sees the data at the next negedge, so a CPU cycle is one full clock.
//  RUN, device port (true dual-port behaviour): sampled at posedge when dev_gnt=1.
//   - Read: dev_rdata <= mem[dev_addr], dev_valid=1 for the following cycle.
//     Back-to-back reads give continuous dev_valid.
//   - Write: mem[dev_addr] <= dev_wdata; dev_valid stays 0.
//   - Same edge, same address, both writing: CPU write wins, device write is dropped, dev_collide pulses for 1 cycle.
//   - Device read and CPU write to the same address on one edge: device gets the new (CPU) data.
//   - CPU read and device write to the same address on one edge: RAM_data gets the device data (write-first).
//  Addresses wrap modulo 2**ADDR_W; upper input bits beyond ADDR_W are ignored.
//  RESET mid-CLEAR restarts the sweep at 0.
//  RESET in RUN aborts any pending dev_valid. Memory contents are preserved if CLEAR_ON_RESET=0.
// CONFIGURATION
//  DCPU_RAM_PARITY_EN defined:
//   - Each word stores one extra even-parity bit, computed on every write (CPU, device, clear).
//   - Every CPU or device read recomputes parity; a mismatch sets parity_err=1.
//   - parity_err stays set until RESET.
//  DCPU_RAM_PARITY_EN undefined: no parity storage, parity_err tied to 0.
// TESTING (ADDR_W=4 unless noted)
//  1 Release RESET, CLEAR_ON_RESET=1 -> ready=0 for 16 posedges, then 1; reads of addr 0..15 all return 0x0000.
//  2 CPU RAM_wr=1 addr 0x5 data 0x1234, then read addr 0x5 -> RAM_data=0x1234 one posedge later.
//    Same-edge write+read of 0x5 with 0xBEEF -> RAM_data=0xBEEF.
//  3 dev_req=1, dev_we=0, dev_addr=0x5 -> dev_gnt=1 that cycle; dev_valid=1 and dev_rdata=0x1234 the next cycle.
//  4 Both ports write addr 0x3 on one edge (CPU 0xAAAA, dev 0x5555) -> mem[3]=0xAAAA, dev_collide high exactly 1 cycle.
//  5 Assert RESET when the clear counter=7, release -> sweep restarts at 0; ready after 16 more posedges; dev_gnt=0 throughout.
//  6 With DCPU_RAM_PARITY_EN: backdoor-flip bit 0 of mem[0x2], CPU read 0x2 -> parity_err=1 and stays 1 until RESET.

Source files
------------

// File: rtl/dcpu_ram_responder.sv
// rtl/dcpu_ram_responder.sv - DCPU RAM responder: CPU port plus device port onto one word store
// Optional feature: define DCPU_RAM_PARITY_EN to store and check one even-parity bit per word.
// All state updates on posedge CORE_CLK so CPU read data is settled by the CPU's negedge sample.
module dcpu_ram_responder #(
  parameter int ADDR_W         = 16,
  parameter int DATA_W         = 16,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic              CORE_CLK,
  input  logic              RESET,
  input  logic [ADDR_W-1:0] RAM_addr,
  input  logic [DATA_W-1:0] RAM_out,
  input  logic              RAM_wr,
  output logic [DATA_W-1:0] RAM_data,
  output logic              ready,
  input  logic              dev_req,
  input  logic [ADDR_W-1:0] dev_addr,
  input  logic [DATA_W-1:0] dev_wdata,
  input  logic              dev_we,
  output logic              dev_gnt,
  output logic [DATA_W-1:0] dev_rdata,
  output logic              dev_valid,
  output logic              dev_collide,
  output logic              parity_err
);

  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  state_t            state_q;
  state_t            state_d;
  logic [ADDR_W-1:0] cnt_q;

  // Word store; no reset so contents survive RESET when the sweep is disabled.
  logic [DATA_W-1:0] mem [DEPTH];
`ifdef DCPU_RAM_PARITY_EN
  logic              par_mem [DEPTH];
  logic              parity_err_q;
  logic              cpu_par_bad;
  logic              dev_par_bad;
`endif

  logic run;
  logic cpu_we;
  logic same_addr;
  logic dev_wr_req;
  logic dev_drop;
  logic dev_wr;
  logic dev_rd;
  logic cpu_fwd_cpu;
  logic cpu_fwd_dev;
  logic dev_fwd_cpu;

  // Port qualification: nothing is accepted until the clear sweep has finished.
  assign run         = (state_q == ST_RUN);
  assign ready       = run;
  assign dev_gnt     = dev_req & run;
  assign cpu_we      = RAM_wr & run;
  assign same_addr   = (RAM_addr == dev_addr);
  assign dev_wr_req  = dev_gnt & dev_we;
  // CPU wins a same-address write race; the device write is dropped and reported.
  assign dev_drop    = dev_wr_req & cpu_we & same_addr;
  assign dev_wr      = dev_wr_req & ~dev_drop;
  assign dev_rd      = dev_gnt & ~dev_we;
  // Write-first forwarding paths for same-edge read/write of one address.
  assign cpu_fwd_cpu = cpu_we;
  assign cpu_fwd_dev = ~cpu_we & dev_wr & same_addr;
  assign dev_fwd_cpu = cpu_we & same_addr;

  // State register: reset selects the sweep or direct service.
  always_ff @(posedge CORE_CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: leave CLEAR after the last word has been zeroed.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_CLEAR: if (&cnt_q) state_d = ST_RUN;
      ST_RUN:   state_d = ST_RUN;
      default:  state_d = ST_CLEAR;
    endcase
  end

  // Clear sweep counter: restarts at 0 on every RESET.
  always_ff @(posedge CORE_CLK or posedge RESET) begin
    if (RESET) begin
      cnt_q <= '0;
    end else if (state_q == ST_CLEAR) begin
      cnt_q <= cnt_q + ADDR_W'(1);
    end
  end

  // Memory writes: sweep zeroes one word per edge; in RUN the CPU write is issued last.
  always_ff @(posedge CORE_CLK) begin
    if (state_q == ST_CLEAR) begin
      mem[cnt_q] <= '0;
`ifdef DCPU_RAM_PARITY_EN
      par_mem[cnt_q] <= 1'b0;
`endif
    end else begin
      if (dev_wr) begin
        mem[dev_addr] <= dev_wdata;
`ifdef DCPU_RAM_PARITY_EN
        par_mem[dev_addr] <= ^dev_wdata;
`endif
      end
      if (cpu_we) begin
        mem[RAM_addr] <= RAM_out;
`ifdef DCPU_RAM_PARITY_EN
        par_mem[RAM_addr] <= ^RAM_out;
`endif
      end
    end
  end

  // Read ports: registered, write-first, with device valid/collide pulses.
  always_ff @(posedge CORE_CLK or posedge RESET) begin
    if (RESET) begin
      RAM_data    <= '0;
      dev_rdata   <= '0;
      dev_valid   <= 1'b0;
      dev_collide <= 1'b0;
    end else if (!run) begin
      RAM_data    <= '0;
      dev_valid   <= 1'b0;
      dev_collide <= 1'b0;
    end else begin
      if (cpu_fwd_cpu) begin
        RAM_data <= RAM_out;
      end else if (cpu_fwd_dev) begin
        RAM_data <= dev_wdata;
      end else begin
        RAM_data <= mem[RAM_addr];
      end
      if (dev_rd) begin
        dev_rdata <= dev_fwd_cpu ? RAM_out : mem[dev_addr];
      end
      dev_valid   <= dev_rd;
      dev_collide <= dev_drop;
    end
  end

`ifdef DCPU_RAM_PARITY_EN
  // Parity is only checked on words actually fetched from the store, not forwarded data.
  assign cpu_par_bad = run & ~cpu_fwd_cpu & ~cpu_fwd_dev & ((^mem[RAM_addr]) != par_mem[RAM_addr]);
  assign dev_par_bad = dev_rd & ~dev_fwd_cpu & ((^mem[dev_addr]) != par_mem[dev_addr]);

  // Sticky parity error: cleared only by RESET.
  always_ff @(posedge CORE_CLK or posedge RESET) begin
    if (RESET) begin
      parity_err_q <= 1'b0;
    end else if (cpu_par_bad || dev_par_bad) begin
      parity_err_q <= 1'b1;
    end
  end

  assign parity_err = parity_err_q;
`else
  assign parity_err = 1'b0;
`endif

endmodule
